// File: rtl/lcd_fetch_seq.sv
// lcd_fetch_seq
//  Sequences screen-memory fetches for one LCD pixel row. For every character
//  cell it reads the 2-byte attribute from the Screen Base File, then the font
//  byte from one of the four font banks, and offers that byte downstream with
//  a valid/ready handshake. The physical memory bus is shared with the Z80.
//  The CPU has priority, but a fetch that has waited MAXWAIT cycles takes a
//  slot anyway and stretches the CPU clock with cpu_wait for that slot.
//
// Ports
//  mck, rin            master clock, asynchronous active-high reset
//  en, line_start      fetch enable and row-start pulse
//  prow                pixel row 0-63, latched at an accepted line_start
//  pb0..pb3, sbr       font bank bases and Screen Base File base, latched likewise
//  cpu_req, md         Z80 request pending, memory read data
//  lcd_ma, lcd_oe      fetch address and bus ownership
//  cpu_wait            Z80 clock stretch during a forced slot
//  pix_data, pix_attr  font byte and attribute flags hi[7:4] of the cell
//  pix_valid/pix_ready downstream handshake
//  busy, line_done     row in progress, 1-cycle pulse at row end
//  overrun             1-cycle pulse when line_start arrives mid-row
module lcd_fetch_seq #(
    parameter int COLS    = 108,
    parameter int RD_CYC  = 2,
    parameter int MAXWAIT = 4
) (
    input  logic        mck,
    input  logic        rin,
    input  logic        en,
    input  logic        line_start,
    input  logic [5:0]  prow,
    input  logic [12:0] pb0,
    input  logic [9:0]  pb1,
    input  logic [8:0]  pb2,
    input  logic [10:0] pb3,
    input  logic [10:0] sbr,
    input  logic        cpu_req,
    input  logic [7:0]  md,
    output logic [21:0] lcd_ma,
    output logic        lcd_oe,
    output logic        cpu_wait,
    output logic [7:0]  pix_data,
    output logic [3:0]  pix_attr,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        busy,
    output logic        line_done,
    output logic        overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALO,
        S_AHI,
        S_FONT,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [2:0] RD_LAST  = 3'(RD_CYC - 1);
    localparam logic [4:0] WAIT_LIM = 5'(MAXWAIT);
    localparam logic [6:0] COL_LAST = 7'(COLS - 1);

    state_t      state_q, state_d;
    logic [6:0]  col_q, col_d;
    logic [2:0]  rd_q, rd_d;
    logic [3:0]  wait_q, wait_d;
    logic [10:0] sbr_q, sbr_d;
    logic [5:0]  prow_q, prow_d;
    logic [12:0] pb0_q, pb0_d;
    logic [9:0]  pb1_q, pb1_d;
    logic [8:0]  pb2_q, pb2_d;
    logic [10:0] pb3_q, pb3_d;
    logic [7:0]  attr_lo_q, attr_lo_d;
    logic [7:0]  attr_hi_q, attr_hi_d;
    logic [21:0] lcd_ma_q, lcd_ma_d;
    logic        lcd_oe_q, lcd_oe_d;
    logic        cpu_wait_q, cpu_wait_d;
    logic [7:0]  pix_data_q, pix_data_d;
    logic [3:0]  pix_attr_q, pix_attr_d;
    logic        pix_valid_q, pix_valid_d;
    logic        busy_q, busy_d;
    logic        line_done_q, line_done_d;
    logic        overrun_q, overrun_d;

    logic [10:0] sbr_src;
    logic [5:0]  prow_src;
    logic [6:0]  col_src;
    logic [7:0]  hi_src;
    logic [8:0]  code9;
    logic [21:0] alo_addr;
    logic [21:0] font_addr;
    logic        mem_enter;
    state_t      mem_next;
    logic [4:0]  wait_inc;

    function automatic logic [21:0] pick_addr(input state_t t, input logic [21:0] a_lo,
                                              input logic [21:0] a_font);
        if (t == S_FONT)
            return a_font;
        else if (t == S_AHI)
            return {a_lo[21:1], 1'b1};
        else
            return a_lo;
    endfunction

    // Addresses are computed for the slot about to be granted. In IDLE the
    // live inputs are used because the snapshot is being taken on that very
    // edge; leaving OUT means the next column; leaving AHI the high attribute
    // byte is still on md.
    always_comb begin
        sbr_src  = (state_q == S_IDLE) ? sbr  : sbr_q;
        prow_src = (state_q == S_IDLE) ? prow : prow_q;
        if (state_q == S_IDLE)
            col_src = '0;
        else if (state_q == S_OUT)
            col_src = col_q + 7'd1;
        else
            col_src = col_q;
        hi_src   = (state_q == S_AHI) ? md : attr_hi_q;
        code9    = {hi_src[0], attr_lo_q};
        alo_addr = {sbr_src, prow_src[5:3], col_src, 1'b0};
        if (hi_src[1]) begin
            if (hi_src[0])
                font_addr = {pb3_q, attr_lo_q, prow_q[2:0]};
            else
                font_addr = {pb2_q, 2'b00, attr_lo_q, prow_q[2:0]};
        end else if (code9 >= 9'h1C0) begin
            font_addr = {pb0_q, code9[5:0], prow_q[2:0]};
        end else begin
            font_addr = {pb1_q, code9, prow_q[2:0]};
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        rd_d        = rd_q;
        wait_d      = wait_q;
        sbr_d       = sbr_q;
        prow_d      = prow_q;
        pb0_d       = pb0_q;
        pb1_d       = pb1_q;
        pb2_d       = pb2_q;
        pb3_d       = pb3_q;
        attr_lo_d   = attr_lo_q;
        attr_hi_d   = attr_hi_q;
        lcd_ma_d    = lcd_ma_q;
        lcd_oe_d    = lcd_oe_q;
        cpu_wait_d  = cpu_wait_q;
        pix_data_d  = pix_data_q;
        pix_attr_d  = pix_attr_q;
        pix_valid_d = pix_valid_q;
        line_done_d = 1'b0;
        overrun_d   = line_start && en && (state_q != S_IDLE);
        mem_enter   = 1'b0;
        mem_next    = state_q;
        // Cycles waited including the current one.
        wait_inc    = {1'b0, wait_q} + 5'd1;

        case (state_q)
            S_IDLE: begin
                if (line_start && en) begin
                    sbr_d     = sbr;
                    prow_d    = prow;
                    pb0_d     = pb0;
                    pb1_d     = pb1;
                    pb2_d     = pb2;
                    pb3_d     = pb3;
                    col_d     = '0;
                    mem_enter = 1'b1;
                    mem_next  = S_ALO;
                end
            end

            S_ALO, S_AHI, S_FONT: begin
                if (lcd_oe_q) begin
                    // A granted slot runs to completion regardless of cpu_req.
                    if (rd_q == RD_LAST) begin
                        lcd_oe_d   = 1'b0;
                        cpu_wait_d = 1'b0;
                        rd_d       = '0;
                        case (state_q)
                            S_ALO: begin
                                attr_lo_d = md;
                                mem_enter = 1'b1;
                                mem_next  = S_AHI;
                            end
                            S_AHI: begin
                                attr_hi_d = md;
                                mem_enter = 1'b1;
                                mem_next  = S_FONT;
                            end
                            default: begin
                                pix_data_d  = md;
                                pix_attr_d  = attr_hi_q[7:4];
                                pix_valid_d = 1'b1;
                                state_d     = S_OUT;
                            end
                        endcase
                    end else begin
                        rd_d = rd_q + 3'd1;
                    end
                end else if (!cpu_req || wait_inc >= WAIT_LIM) begin
                    // Forced only if the CPU still wants the bus.
                    lcd_oe_d   = 1'b1;
                    cpu_wait_d = cpu_req;
                    wait_d     = '0;
                    rd_d       = '0;
                    lcd_ma_d   = pick_addr(state_q, alo_addr, font_addr);
                end else begin
                    // Grant is forced on reaching the limit, so the counter
                    // never has to hold more than MAXWAIT-1.
                    wait_d = wait_inc[3:0];
                end
            end

            S_OUT: begin
                if (pix_ready) begin
                    pix_valid_d = 1'b0;
                    if (col_q == COL_LAST) begin
                        state_d     = S_DONE;
                        line_done_d = 1'b1;
                    end else begin
                        col_d     = col_q + 7'd1;
                        mem_enter = 1'b1;
                        mem_next  = S_ALO;
                    end
                end
            end

            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase

        // Entering a memory state: the bus is taken straight away when the
        // CPU is idle, otherwise the state starts in the waiting phase.
        if (mem_enter) begin
            state_d = mem_next;
            wait_d  = '0;
            rd_d    = '0;
            if (!cpu_req) begin
                lcd_oe_d   = 1'b1;
                cpu_wait_d = 1'b0;
                lcd_ma_d   = pick_addr(mem_next, alo_addr, font_addr);
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge mck or posedge rin) begin
        if (rin) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            rd_q        <= '0;
            wait_q      <= '0;
            sbr_q       <= '0;
            prow_q      <= '0;
            pb0_q       <= '0;
            pb1_q       <= '0;
            pb2_q       <= '0;
            pb3_q       <= '0;
            attr_lo_q   <= '0;
            attr_hi_q   <= '0;
            lcd_ma_q    <= '0;
            lcd_oe_q    <= 1'b0;
            cpu_wait_q  <= 1'b0;
            pix_data_q  <= '0;
            pix_attr_q  <= '0;
            pix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            line_done_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            rd_q        <= rd_d;
            wait_q      <= wait_d;
            sbr_q       <= sbr_d;
            prow_q      <= prow_d;
            pb0_q       <= pb0_d;
            pb1_q       <= pb1_d;
            pb2_q       <= pb2_d;
            pb3_q       <= pb3_d;
            attr_lo_q   <= attr_lo_d;
            attr_hi_q   <= attr_hi_d;
            lcd_ma_q    <= lcd_ma_d;
            lcd_oe_q    <= lcd_oe_d;
            cpu_wait_q  <= cpu_wait_d;
            pix_data_q  <= pix_data_d;
            pix_attr_q  <= pix_attr_d;
            pix_valid_q <= pix_valid_d;
            busy_q      <= busy_d;
            line_done_q <= line_done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign lcd_ma    = lcd_ma_q;
    assign lcd_oe    = lcd_oe_q;
    assign cpu_wait  = cpu_wait_q;
    assign pix_data  = pix_data_q;
    assign pix_attr  = pix_attr_q;
    assign pix_valid = pix_valid_q;
    assign busy      = busy_q;
    assign line_done = line_done_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_lcd_fetch_seq.sv
// tb_lcd_fetch_seq
//  Directed bench for lcd_fetch_seq built with COLS=3, RD_CYC=2, MAXWAIT=4.
//  A small memory model answers attribute reads from a per-row table and
//  font reads from a fixed hash of the address.
module tb_lcd_fetch_seq;

    localparam int COLS    = 3;
    localparam int RD_CYC  = 2;
    localparam int MAXWAIT = 4;

    logic        mck;
    logic        rin;
    logic        en;
    logic        line_start;
    logic [5:0]  prow;
    logic [12:0] pb0;
    logic [9:0]  pb1;
    logic [8:0]  pb2;
    logic [10:0] pb3;
    logic [10:0] sbr;
    logic        cpu_req;
    logic [7:0]  md;
    logic [21:0] lcd_ma;
    logic        lcd_oe;
    logic        cpu_wait;
    logic [7:0]  pix_data;
    logic [3:0]  pix_attr;
    logic        pix_valid;
    logic        pix_ready;
    logic        busy;
    logic        line_done;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    logic [10:0] memSbr;
    logic [2:0]  memCr;
    logic [7:0]  memLo [0:3];
    logic [7:0]  memHi [0:3];
    logic [21:0] slotQ [$];
    logic [11:0] pixQ [$];
    logic        prevOe;
    logic [21:0] prevMa;

    lcd_fetch_seq #(
        .COLS    (COLS),
        .RD_CYC  (RD_CYC),
        .MAXWAIT (MAXWAIT)
    ) dut (
        .mck        (mck),
        .rin        (rin),
        .en         (en),
        .line_start (line_start),
        .prow       (prow),
        .pb0        (pb0),
        .pb1        (pb1),
        .pb2        (pb2),
        .pb3        (pb3),
        .sbr        (sbr),
        .cpu_req    (cpu_req),
        .md         (md),
        .lcd_ma     (lcd_ma),
        .lcd_oe     (lcd_oe),
        .cpu_wait   (cpu_wait),
        .pix_data   (pix_data),
        .pix_attr   (pix_attr),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .busy       (busy),
        .line_done  (line_done),
        .overrun    (overrun)
    );

    // Free-running master clock, 10 time units per cycle.
    initial mck = 1'b0;
    always #5 mck = ~mck;

    // Font bytes are a fixed hash of the address so every font slot gives a
    // distinct, predictable value.
    function automatic logic [7:0] fontByte(input logic [21:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // Memory model: attribute area of the current row answers from the
    // table, everything else is font.
    always_comb begin
        if (lcd_ma[21:11] == memSbr && lcd_ma[10:8] == memCr && lcd_ma[7:1] < 7'd3)
            md = lcd_ma[0] ? memHi[lcd_ma[2:1]] : memLo[lcd_ma[2:1]];
        else
            md = fontByte(lcd_ma);
    end

    // Monitor: records each new bus slot address and each accepted pixel
    // byte, sampling mid-cycle after the bench has driven its inputs.
    always @(negedge mck) begin
        #2;
        if (lcd_oe && (!prevOe || lcd_ma != prevMa))
            slotQ.push_back(lcd_ma);
        if (pix_valid && pix_ready)
            pixQ.push_back({pix_attr, pix_data});
        prevOe = lcd_oe;
        prevMa = lcd_ma;
    end

    // Hard stop in case something never finishes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Loads the row's memory table and input snapshot, then raises
    // line_start; the caller lowers it on the next negedge.
    task automatic applyStimulus(input logic [10:0] s, input logic [5:0] p,
                                 input logic [7:0] lo0, input logic [7:0] hi0,
                                 input logic [7:0] lo1, input logic [7:0] hi1,
                                 input logic [7:0] lo2, input logic [7:0] hi2);
        sbr      = s;
        prow     = p;
        memSbr   = s;
        memCr    = p[5:3];
        memLo[0] = lo0;
        memHi[0] = hi0;
        memLo[1] = lo1;
        memHi[1] = hi1;
        memLo[2] = lo2;
        memHi[2] = hi2;
        memLo[3] = 8'h00;
        memHi[3] = 8'h00;
        slotQ.delete();
        pixQ.delete();
        line_start = 1'b1;
    endtask

    // Waits (bounded) for the row-end pulse, then confirms the block idles.
    task automatic waitLineDone();
        int n;
        n = 0;
        while (line_done !== 1'b1 && n < 300) begin
            @(negedge mck);
            n++;
        end
        checkOutput("line_done", line_done, 1);
        @(negedge mck);
        checkOutput("busy_after_row", busy, 0);
    endtask

    initial begin
        int n;
        rin        = 1'b1;
        en         = 1'b1;
        line_start = 1'b0;
        prow       = '0;
        pb0        = '0;
        pb1        = '0;
        pb2        = '0;
        pb3        = '0;
        sbr        = '0;
        cpu_req    = 1'b0;
        pix_ready  = 1'b1;
        memSbr     = '0;
        memCr      = '0;
        prevOe     = 1'b0;
        prevMa     = '0;
        for (int i = 0; i < 4; i++) begin
            memLo[i] = 8'h00;
            memHi[i] = 8'h00;
        end

        // Reset values.
        repeat (3) @(negedge mck);
        checkOutput("reset_ma", lcd_ma, 0);
        checkOutput("reset_flags",
                    {lcd_oe, cpu_wait, pix_data, pix_attr, pix_valid, busy, line_done, overrun}, 0);
        rin = 1'b0;
        @(negedge mck);

        // line_start with en low is ignored and does not flag overrun.
        en         = 1'b0;
        line_start = 1'b1;
        @(negedge mck);
        line_start = 1'b0;
        checkOutput("en0_busy", busy, 0);
        @(negedge mck);
        checkOutput("en0_overrun", overrun, 0);
        checkOutput("en0_oe", lcd_oe, 0);
        en = 1'b1;

        // Row A: free bus, lores via pb1, exact cycle timing of cell 0.
        pb1 = 10'h001;
        applyStimulus(11'h000, 6'd0, 8'h41, 8'h00, 8'h42, 8'h00, 8'h43, 8'h00);
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge mck);
            if (cyc == 1) begin
                line_start = 1'b0;
                checkOutput("a_alo_oe", lcd_oe, 1);
                checkOutput("a_alo_ma", lcd_ma, 22'h000000);
                checkOutput("a_busy", busy, 1);
            end
            if (cyc == 3) checkOutput("a_ahi_ma", lcd_ma, 22'h000001);
            if (cyc == 5) checkOutput("a_font_ma", lcd_ma, 22'h001208);
            if (cyc == 6) checkOutput("a_valid_early", pix_valid, 0);
            if (cyc == 7) begin
                checkOutput("a_valid_c7", pix_valid, 1);
                checkOutput("a_pix_data", pix_data, fontByte(22'h001208));
            end
        end
        waitLineDone();
        checkOutput("a_slots", slotQ.size(), 9);
        checkOutput("a_pixes", pixQ.size(), 3);
        if (slotQ.size() == 9) begin
            checkOutput("a_c2_alo", slotQ[6], 22'h000004);
            checkOutput("a_c2_font", slotQ[8], 22'h001218);
        end
        if (pixQ.size() == 3)
            checkOutput("a_c2_pix", pixQ[2], {4'h0, fontByte(22'h001218)});

        // Row B: lores bank 0, hires bank 3, lores bank 1 with code9 bit 8.
        pb0 = 13'h0123;
        pb1 = 10'h001;
        pb3 = 11'h5A5;
        applyStimulus(11'h155, 6'd3, 8'hC5, 8'h01, 8'h22, 8'h83, 8'h10, 8'h41);
        @(negedge mck);
        line_start = 1'b0;
        waitLineDone();
        checkOutput("b_slots", slotQ.size(), 9);
        if (slotQ.size() == 9) begin
            checkOutput("b_c0_alo", slotQ[0], 22'h0AA800);
            checkOutput("b_c0_font", slotQ[2], 22'h02462B);
            checkOutput("b_c1_ahi", slotQ[4], 22'h0AA803);
            checkOutput("b_c1_font", slotQ[5], 22'h2D2913);
            checkOutput("b_c2_font", slotQ[8], 22'h001883);
        end
        checkOutput("b_pixes", pixQ.size(), 3);
        if (pixQ.size() == 3) begin
            checkOutput("b_c0_pix", pixQ[0], {4'h0, fontByte(22'h02462B)});
            checkOutput("b_c1_pix", pixQ[1], {4'h8, fontByte(22'h2D2913)});
            checkOutput("b_c2_pix", pixQ[2], {4'h4, fontByte(22'h001883)});
        end

        // Row C: CPU holds the bus (forced slot), then downstream stalls.
        pb1       = 10'h3FF;
        pb2       = 9'h1F0;
        pb3       = 11'h001;
        cpu_req   = 1'b1;
        pix_ready = 1'b0;
        applyStimulus(11'h2AA, 6'd9, 8'h10, 8'h82, 8'h11, 8'h00, 8'h7E, 8'h03);
        @(negedge mck);
        line_start = 1'b0;
        checkOutput("c_busy", busy, 1);
        checkOutput("c_wait_oe", lcd_oe, 0);
        for (int cyc = 2; cyc <= 4; cyc++) begin
            @(negedge mck);
            checkOutput("c_wait_oe", lcd_oe, 0);
        end
        @(negedge mck);
        checkOutput("c_forced_oe", lcd_oe, 1);
        checkOutput("c_forced_wait", cpu_wait, 1);
        checkOutput("c_forced_ma", lcd_ma, 22'h155100);
        @(negedge mck);
        checkOutput("c_forced_wait2", cpu_wait, 1);
        @(negedge mck);
        checkOutput("c_wait_end", cpu_wait, 0);
        checkOutput("c_oe_end", lcd_oe, 0);
        cpu_req = 1'b0;
        @(negedge mck);
        checkOutput("c_ahi_oe", lcd_oe, 1);
        checkOutput("c_ahi_wait", cpu_wait, 0);
        checkOutput("c_ahi_ma", lcd_ma, 22'h155101);
        n = 0;
        while (pix_valid !== 1'b1 && n < 50) begin
            @(negedge mck);
            n++;
        end
        checkOutput("c_valid", pix_valid, 1);
        for (int i = 0; i < 10; i++) begin
            checkOutput("c_stall_valid", pix_valid, 1);
            checkOutput("c_stall_data", pix_data, fontByte(22'h3E0081));
            checkOutput("c_stall_attr", pix_attr, 4'h8);
            checkOutput("c_stall_oe", lcd_oe, 0);
            if (i == 2) begin
                line_start = 1'b1;
                sbr        = 11'h000;
                prow       = 6'd0;
            end
            if (i == 3) begin
                line_start = 1'b0;
                checkOutput("c_overrun", overrun, 1);
            end
            if (i == 4) checkOutput("c_overrun_end", overrun, 0);
            @(negedge mck);
        end
        pix_ready = 1'b1;
        waitLineDone();
        checkOutput("c_slots", slotQ.size(), 9);
        if (slotQ.size() == 9) begin
            checkOutput("c_c0_font", slotQ[2], 22'h3E0081);
            checkOutput("c_c1_alo", slotQ[3], 22'h155102);
            checkOutput("c_c1_font", slotQ[5], 22'h3FF089);
            checkOutput("c_c2_font", slotQ[8], 22'h000BF1);
        end
        if (pixQ.size() == 3)
            checkOutput("c_c0_pix", pixQ[0], {4'h8, fontByte(22'h3E0081)});

        // Row D: reset in the middle of cell 1's font read, then restart.
        pb1 = 10'h001;
        applyStimulus(11'h000, 6'd0, 8'h41, 8'h00, 8'h42, 8'h00, 8'h43, 8'h00);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge mck);
            if (cyc == 1) line_start = 1'b0;
        end
        checkOutput("d_font_oe", lcd_oe, 1);
        checkOutput("d_font_ma", lcd_ma, 22'h001210);
        rin = 1'b1;
        #1;
        checkOutput("d_abort_ma", lcd_ma, 0);
        checkOutput("d_abort_flags", {lcd_oe, cpu_wait, pix_valid, busy, line_done, overrun}, 0);
        @(negedge mck);
        rin = 1'b0;
        @(negedge mck);
        applyStimulus(11'h000, 6'd0, 8'h41, 8'h00, 8'h42, 8'h00, 8'h43, 8'h00);
        @(negedge mck);
        line_start = 1'b0;
        checkOutput("d_restart_oe", lcd_oe, 1);
        checkOutput("d_restart_ma", lcd_ma, 22'h000000);
        repeat (2) @(negedge mck);
        checkOutput("d_restart_ahi", lcd_ma, 22'h000001);
        waitLineDone();
        checkOutput("d_pixes", pixQ.size(), 3);
        if (pixQ.size() == 3)
            checkOutput("d_c0_pix", pixQ[0], {4'h0, fontByte(22'h001208)});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
